slow_toggle_tx: RTL and testbench
=================================

Name: slow_toggle_tx

Overview:
- Launch side of the toggle-handshake CDC link between the slow_clk and fast_clk domains, running entirely on slow_clk.
- Accepts one word per valid/ready handshake and holds it stable on data_out. Signals the new word by flipping req_tgl.
- The fast-domain receiver captures the word and flips ack_tgl back; this block synchronises ack_tgl and releases for the next word.
- Provides transfer counting, a sticky ack timeout and a sticky protocol-error flag.

Parameters:
- DATA_W, 4, width of the transferred word.
- SYNC_STAGES, 2, number of slow_clk flops on the ack_tgl synchroniser; legal range 2..4.
- TIMEOUT_CYC, 255, slow_clk cycles in WAIT_ACK before timeout_err sets; 0 disables the timeout.
- CNT_W, 8, width of xfer_cnt and of the timeout counter.

Ports:
- slow_clk  in  1  block clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  upstream word.
- in_ready  out  1  block can accept a word.
- ack_tgl  in  1  receiver acknowledge toggle; fast_clk domain, treated as asynchronous.
- req_tgl  out  1  request toggle to receiver; registered.
- data_out  out  DATA_W  held word to receiver; registered.
- busy  out  1  transfer outstanding.
- xfer_cnt  out  CNT_W  completed transfers; wraps.
- timeout_err  out  1  sticky ack timeout.
- proto_err  out  1  sticky: ack toggled while no request was outstanding.
- err_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset values (rst asynchronous, active-high): req_tgl=0, data_out=0, all synchroniser flops=0, state=IDLE, xfer_cnt=0, timeout counter=0, timeout_err=0, proto_err=0.
- ack_s: the last stage of the SYNC_STAGES-deep synchroniser on ack_tgl. It is the only use of ack_tgl.
- Invariant: in IDLE, ack_s==req_tgl.
- FSM, state IDLE:
  - in_ready=1, busy=0.
  - On in_valid&&in_ready at an edge: data_out<=in_data; req_tgl<=~req_tgl; timeout counter<=0; state<=WAIT_ACK.
- FSM, state WAIT_ACK:
  - in_ready=0, busy=1; data_out and req_tgl held constant.
  - When ack_s==req_tgl: state<=IDLE; xfer_cnt<=xfer_cnt+1, wrapping at 2^CNT_W-1 -> 0.
- in_ready and busy are decoded from state only, so in_ready has no combinational path from in_valid.
- Latency:
  - req_tgl flips on the accepting edge.
  - ack_s reflects an ack_tgl change SYNC_STAGES edges later.
  - The next accept is possible on the edge after ack_s matches.
  - Minimum period per word is therefore SYNC_STAGES+2 cycles plus receiver latency.
- Timeout:
  - In WAIT_ACK the counter increments each cycle and saturates at 2^CNT_W-1.
  - When the counter reaches TIMEOUT_CYC (TIMEOUT_CYC≠0), timeout_err<=1.
  - The block keeps waiting; it never re-toggles, retries or aborts.
- Protocol error: in IDLE, ack_s!=req_tgl sets proto_err<=1 and the FSM stays in IDLE. The accept on that edge still proceeds normally.
- err_clr clears both sticky flags. If a set condition and err_clr occur on the same edge, the set wins.
- in_valid deasserting while in WAIT_ACK has no effect.
- Reset mid-transfer returns everything to reset values. The receiver is reset by the same rst, so both toggles restart at 0.

Decomposition:
- Shared package slow_toggle_pkg:
  - state enum {IDLE, WAIT_ACK};
  - default constants for DATA_W, SYNC_STAGES and TIMEOUT_CYC, shared with the fast-domain receiver.
- One sub-module, toggle_sync_bit:
  - parameterised SYNC_STAGES-deep flop chain;
  - asynchronous reset to 0;
  - reusable by the receiver for req_tgl.

Test Plan:
- Reset, then one word: rst pulse, then in_valid=1, in_data=4'hA → data_out=4'hA and req_tgl=1 on the accepting edge. Model flips ack_tgl 3 cycles later → in_ready returns SYNC_STAGES+1 edges after the flip; xfer_cnt=1.
- Back-to-back: 300 words with in_valid held high and a model acking after 1 cycle → no lost or duplicated words (scoreboard), xfer_cnt=300 mod 256=44, in_ready never high in WAIT_ACK.
- Timeout: TIMEOUT_CYC=10, model never acks → timeout_err=1 exactly 10 cycles after accept, req_tgl unchanged. A late ack then → IDLE and xfer_cnt increments. err_clr → timeout_err=0.
- Protocol error: flip ack_tgl while in IDLE → proto_err=1 SYNC_STAGES edges later. Pulse err_clr on the same edge as a second spurious flip's detection → proto_err stays 1.
- Reset mid-transfer: assert rst while in WAIT_ACK with req_tgl=1 → req_tgl=0, data_out=0, busy=0, in_ready=1 immediately (asynchronous). The next transfer after rst release completes normally.

Source files
------------

// File: rtl/slow_toggle_pkg.sv
// Shared types and default sizing for the slow->fast toggle-handshake link.
// The fast-domain receiver imports the same defaults so both ends agree.
package slow_toggle_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam int DEF_DATA_W      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/toggle_sync_bit.sv
// Multi-flop synchroniser for a single toggle bit arriving from another clock domain.
// Also used on the receiver side for req_tgl.
module toggle_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/slow_toggle_tx.sv
// Launch side of the toggle-handshake CDC link: holds one word on data_out,
// flips req_tgl per word and waits for the synchronised ack_tgl to match.
module slow_toggle_tx
  import slow_toggle_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              ack_tgl,
  output logic              req_tgl,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              timeout_err,
  output logic              proto_err,
  input  logic              err_clr
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_req;
  logic [DATA_W-1:0]  r_data;
  logic [CNT_W-1:0]   r_xfer_cnt;
  logic [CNT_W-1:0]   r_tcnt;
  logic [CNT_W-1:0]   w_tcnt_inc;
  logic               r_tout;
  logic               r_perr;
  logic               w_ack_s;
  logic               w_accept;
  logic               w_done;
  logic               w_in_ready;
  logic               w_busy;
  logic               w_proto_set;
  logic               w_tout_set;

  toggle_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .i_clk(slow_clk),
    .i_rst(rst),
    .i_d  (ack_tgl),
    .o_q  (w_ack_s)
  );

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // in_ready/busy depend on state only, never on in_valid.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_in_ready   = 1'b0;
    w_busy       = 1'b0;
    w_proto_set  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready  = 1'b1;
        w_proto_set = (w_ack_s != r_req);
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        w_busy = 1'b1;
        if (w_ack_s == r_req) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_tcnt_inc = (&r_tcnt) ? r_tcnt : r_tcnt + CNT_W'(1);
  assign w_tout_set = (r_state == WAIT_ACK) && (TIMEOUT_CYC != 0) && (w_tcnt_inc == TIMEOUT_VAL);

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      r_req      <= 1'b0;
      r_data     <= '0;
      r_tcnt     <= '0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_data <= in_data;
        r_req  <= ~r_req;
        r_tcnt <= '0;
      end else if (r_state == WAIT_ACK) begin
        r_tcnt <= w_tcnt_inc;
      end
      if (w_done) begin
        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
    end
  end

  // A set condition outranks err_clr on the same edge.
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      r_tout <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_tout_set) begin
        r_tout <= 1'b1;
      end else if (err_clr) begin
        r_tout <= 1'b0;
      end
      if (w_proto_set) begin
        r_perr <= 1'b1;
      end else if (err_clr) begin
        r_perr <= 1'b0;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign busy        = w_busy;
  assign req_tgl     = r_req;
  assign data_out    = r_data;
  assign xfer_cnt    = r_xfer_cnt;
  assign timeout_err = r_tout;
  assign proto_err   = r_perr;

endmodule

// File: tb/tb_slow_toggle_tx.sv
// Randomised bench for slow_toggle_tx: cycle-level reference model, a receiver
// agent on the toggle link and a word scoreboard.
module tb_slow_toggle_tx;

  localparam int DW = 4;
  localparam int SS = 2;
  localparam int TO = 10;
  localparam int CW = 8;

  logic          slow_clk = 1'b0;
  logic          rst      = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_ready;
  logic          ack_tgl  = 1'b0;
  logic          req_tgl;
  logic [DW-1:0] data_out;
  logic          busy;
  logic [CW-1:0] xfer_cnt;
  logic          timeout_err;
  logic          proto_err;
  logic          err_clr  = 1'b0;

  slow_toggle_tx #(
    .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO), .CNT_W(CW)
  ) dut (
    .slow_clk(slow_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ack_tgl(ack_tgl), .req_tgl(req_tgl), .data_out(data_out),
    .busy(busy), .xfer_cnt(xfer_cnt), .timeout_err(timeout_err),
    .proto_err(proto_err), .err_clr(err_clr)
  );

  always #5 slow_clk = ~slow_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding word, ack seen SS edges late.
  bit          m_busy, m_req, m_tout, m_perr;
  bit [DW-1:0] m_data;
  int          m_cnt, m_tcnt;
  bit          ack_hist[SS];
  int          acc_total, rx_total, cyc, flip_cyc;
  bit [DW-1:0] sent_q[$];
  bit          rx_en;
  int          rx_wait, rx_dmin, rx_dmax;

  task automatic model_reset();
    m_busy = 0; m_req = 0; m_tout = 0; m_perr = 0; m_data = '0;
    m_cnt = 0; m_tcnt = 0;
    for (int i = 0; i < SS; i++) ack_hist[i] = 0;
    sent_q.delete();
    rx_wait = -1;
  endtask

  // Computes the state the DUT must hold after the coming edge.
  task automatic model_step();
    bit ack_s;
    if (rst) begin
      model_reset();
      return;
    end
    ack_s = ack_hist[SS-1];
    if (err_clr) begin
      m_tout = 0;
      m_perr = 0;
    end
    if (!m_busy) begin
      if (ack_s != m_req) m_perr = 1;
      if (in_valid) begin
        m_data = in_data;
        m_req  = !m_req;
        m_tcnt = 0;
        m_busy = 1;
        sent_q.push_back(in_data);
        acc_total++;
      end
    end else begin
      if (m_tcnt < (1 << CW) - 1) m_tcnt++;
      if (TO != 0 && m_tcnt == TO) m_tout = 1;
      if (ack_s == m_req) begin
        m_busy = 0;
        m_cnt  = (m_cnt + 1) % (1 << CW);
      end
    end
    for (int i = SS - 1; i > 0; i--) ack_hist[i] = ack_hist[i-1];
    ack_hist[0] = ack_tgl;
  endtask

  task automatic compare_all();
    check("in_ready", in_ready, !m_busy);
    check("busy", busy, m_busy);
    check("req_tgl", req_tgl, m_req);
    check("data_out", data_out, m_data);
    check("xfer_cnt", xfer_cnt, m_cnt);
    check("timeout_err", timeout_err, m_tout);
    check("proto_err", proto_err, m_perr);
  endtask

  // Receiver agent: acks after a random delay and captures the held word.
  task automatic rx_step();
    if (!rx_en) return;
    if (req_tgl !== ack_tgl) begin
      if (rx_wait < 0) rx_wait = $urandom_range(rx_dmax, rx_dmin);
      if (rx_wait == 0) begin
        if (sent_q.size() == 0) check("sb_empty", 1, 0);
        else check("sb_word", data_out, sent_q.pop_front());
        rx_total++;
        ack_tgl  = ~ack_tgl;
        flip_cyc = cyc;
        rx_wait  = -1;
      end else begin
        rx_wait--;
      end
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    model_step();
    @(posedge slow_clk);
    @(negedge slow_clk);
    cyc++;
    compare_all();
    rx_step();
  endtask

  task automatic do_reset();
    rst = 1; ack_tgl = 0; in_valid = 0; err_clr = 0;
    model_reset();
    tick(); tick();
    rst = 0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (m_busy && g < 200) begin tick(); g++; end
    if (g >= 200) check(tag, 1, 0);
  endtask

  initial begin
    rx_en = 1; rx_dmin = 0; rx_dmax = 0;
    model_reset();
    @(negedge slow_clk);

    // Reset state
    do_reset();
    check("rst_req", req_tgl, 0);
    check("rst_ready", in_ready, 1);
    check("rst_cnt", xfer_cnt, 0);

    // Single word with ack 3 cycles after capture
    rx_dmin = 3; rx_dmax = 3;
    in_valid = 1; in_data = 4'hA;
    tick();
    in_valid = 0;
    check("one_data", data_out, 4'hA);
    check("one_req", req_tgl, 1);
    begin
      int g = 0;
      while (!in_ready && g < 50) begin tick(); g++; end
      check("one_ready_lat", cyc - flip_cyc, SS + 1);
    end
    check("one_cnt", xfer_cnt, 1);

    // Back-to-back: 300 words, ack after 1 cycle
    do_reset();
    acc_total = 0; rx_total = 0; rx_dmin = 1; rx_dmax = 1;
    begin
      int g = 0;
      while (acc_total < 300 && g < 20000) begin
        in_valid = 1; in_data = DW'($urandom);
        tick(); g++;
      end
      in_valid = 0;
    end
    wait_idle("b2b_idle_timeout");
    check("b2b_accepted", acc_total, 300);
    check("b2b_rx_total", rx_total, 300);
    check("b2b_cnt", xfer_cnt, 44);

    // Random traffic, occasional slow receiver crossing the timeout
    rx_dmin = 0; rx_dmax = 14;
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(3, 0) != 0);
      in_data  = DW'($urandom);
      err_clr  = ($urandom_range(15, 0) == 0);
      tick();
    end
    in_valid = 0; err_clr = 0;
    wait_idle("rand_idle_timeout");

    // Timeout: receiver silent, then late ack, then clear
    err_clr = 1; tick(); err_clr = 0;
    rx_en = 0;
    in_valid = 1; in_data = DW'($urandom);
    tick();
    in_valid = 0;
    begin
      logic req_at_acc;
      req_at_acc = req_tgl;
      repeat (TO - 1) tick();
      check("to_before", timeout_err, 0);
      tick();
      check("to_at", timeout_err, 1);
      repeat (20) tick();
      check("to_req_held", req_tgl, req_at_acc);
      check("to_still_busy", busy, 1);
    end
    rx_en = 1; rx_dmin = 0; rx_dmax = 0;
    begin
      int c0;
      c0 = m_cnt;
      wait_idle("to_late_ack_timeout");
      check("to_late_cnt", xfer_cnt, (c0 + 1) % 256);
    end
    err_clr = 1; tick(); err_clr = 0;
    check("to_cleared", timeout_err, 0);

    // Protocol error: spurious ack flips while idle
    rx_en = 0;
    ack_tgl = ~ack_tgl;
    repeat (SS) tick();
    check("pe_before", proto_err, 0);
    tick();
    check("pe_set", proto_err, 1);
    err_clr = 1; tick(); err_clr = 0;
    check("pe_set_wins", proto_err, 1);
    ack_tgl = ~ack_tgl;
    repeat (SS + 1) tick();
    err_clr = 1; tick(); err_clr = 0;
    check("pe_cleared", proto_err, 0);
    rx_en = 1;

    // Asynchronous reset in the middle of a transfer
    do_reset();
    rx_en = 0;
    in_valid = 1; in_data = 4'h5;
    tick();
    in_valid = 0;
    repeat (3) tick();
    check("mr_pre_req", req_tgl, 1);
    check("mr_pre_busy", busy, 1);
    #1 rst = 1; ack_tgl = 0;
    #1;
    check("mr_req", req_tgl, 0);
    check("mr_data", data_out, 0);
    check("mr_busy", busy, 0);
    check("mr_ready", in_ready, 1);
    model_reset();
    @(negedge slow_clk);
    tick();
    rst = 0;
    rx_en = 1; rx_dmin = 2; rx_dmax = 2;
    in_valid = 1; in_data = 4'hC;
    tick();
    in_valid = 0;
    check("mr_next_data", data_out, 4'hC);
    wait_idle("mr_idle_timeout");
    check("mr_next_cnt", xfer_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
